// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one 32-bit synchronous data-memory port between the scalar and the
// vector MEM stages. A scalar request is a single word access. A vector
// request is VLEN bits wide and is carried out as BEATS consecutive word
// accesses. When both sides are waiting, round-robin arbitration picks the
// side that was not granted last.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_req/s_we/s_addr/s_wdata   scalar request (held until s_done)
//   s_rdata/s_done/s_stall      scalar load result, completion pulse, freeze
//   v_req/v_we/v_addr/v_wdata   vector request (held until v_done)
//   v_rdata/v_done/v_stall      vector load result, completion pulse, freeze
//   mem_addr/mem_we/mem_wdata   registered memory command (word aligned)
//   mem_rdata                   memory read data, valid one cycle after address
//
// Timing from the IDLE grant cycle 0: scalar done in cycle 3, vector done in
// cycle BEATS+2. The memory command is registered, so it is computed from the
// next state and the live request inputs one cycle before it is presented.
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int VLEN   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [31:0]       s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_done,
  output logic              s_stall,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [31:0]       v_addr,
  input  logic [VLEN-1:0]   v_wdata,
  output logic [VLEN-1:0]   v_rdata,
  output logic              v_done,
  output logic              v_stall,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEATS = VLEN / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    S_ISSUE,
    S_RESP,
    V_ISSUE,
    V_RESP
  } state_t;

  typedef enum logic {
    GNT_SCALAR,
    GNT_VEC
  } grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              s_done_q, s_done_d;
  logic              v_done_q, v_done_d;
  logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
  logic [VLEN-1:0]   v_rdata_q, v_rdata_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              s_elig, v_elig;
  logic              grant_s, grant_v;
  logic [BW-1:0]     prev_beat;
  logic [31:0]       s_word_addr, v_word_addr;
  logic              unused_addr_bits;

  // Byte-offset bits are dropped: the port only does whole-word accesses.
  assign s_word_addr      = {s_addr[31:2], 2'b00};
  assign v_word_addr      = {v_addr[31:2], 2'b00};
  assign unused_addr_bits = ^{s_addr[1:0], v_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    s_done_d     = 1'b0;
    v_done_d     = 1'b0;
    s_rdata_d    = s_rdata_q;
    v_rdata_d    = v_rdata_q;
    prev_beat    = beat_q - BW'(1);
    // A side whose done is pulsing is still holding req for this one cycle;
    // it must not be granted again.
    s_elig       = s_req & ~s_done_q;
    v_elig       = v_req & ~v_done_q;
    grant_s      = 1'b0;
    grant_v      = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_elig && (!v_elig || last_grant_q == GNT_VEC)) begin
          grant_s = 1'b1;
        end else if (v_elig) begin
          grant_v = 1'b1;
        end
        if (grant_s) begin
          state_d      = S_ISSUE;
          last_grant_d = GNT_SCALAR;
        end else if (grant_v) begin
          state_d      = V_ISSUE;
          last_grant_d = GNT_VEC;
          beat_d       = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!s_we) begin
          s_rdata_d = mem_rdata;
        end
        s_done_d = 1'b1;
        state_d  = IDLE;
      end
      V_ISSUE: begin
        // Read data returns one cycle late, so each beat retires the
        // previous beat's lane.
        if (!v_we && beat_q != '0) begin
          v_rdata_d[prev_beat*DATA_W +: DATA_W] = mem_rdata;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = V_RESP;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      V_RESP: begin
        if (!v_we) begin
          v_rdata_d[LAST_BEAT*DATA_W +: DATA_W] = mem_rdata;
        end
        v_done_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory command for the cycle we are about to enter.
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    if (state_d == S_ISSUE) begin
      mem_addr_d  = s_word_addr;
      mem_we_d    = s_we;
      mem_wdata_d = s_wdata;
    end else if (state_d == V_ISSUE) begin
      mem_addr_d  = v_word_addr + (32'(beat_d) << 2);
      mem_we_d    = v_we;
      mem_wdata_d = v_wdata[beat_d*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_VEC;
      beat_q       <= '0;
      s_done_q     <= 1'b0;
      v_done_q     <= 1'b0;
      s_rdata_q    <= '0;
      v_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      s_done_q     <= s_done_d;
      v_done_q     <= v_done_d;
      s_rdata_q    <= s_rdata_d;
      v_rdata_q    <= v_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign s_rdata   = s_rdata_q;
  assign s_done    = s_done_q;
  assign v_rdata   = v_rdata_q;
  assign v_done    = v_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls are combinational so the pipeline is released in the done cycle.
  assign s_stall = s_req & ~s_done_q & ~rst;
  assign v_stall = v_req & ~v_done_q & ~rst;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int DW    = 32;
  localparam int VLEN  = 256;
  localparam int BEATS = VLEN / DW;
  localparam int OWN_NONE = 0;
  localparam int OWN_S    = 1;
  localparam int OWN_V    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_req, s_we;
  logic [31:0]     s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            s_done, s_stall;
  logic            v_req, v_we;
  logic [31:0]     v_addr;
  logic [VLEN-1:0] v_wdata, v_rdata;
  logic            v_done, v_stall;
  logic [31:0]     mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_port_arbiter #(.DATA_W(DW), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_done(s_done), .s_stall(s_stall),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_rdata(v_rdata), .v_done(v_done), .v_stall(v_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEADBEEF;  // word at byte 0x40
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Synchronous memory attached to the DUT port (256 words, aliased).
  logic [31:0] bench_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) bench_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) bench_mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= bench_mem[mem_addr[9:2]];
    end
  end

  // Transaction-timeline reference model: owner of the port and the cycle
  // index inside its operation (grant cycle is 0).
  int              m_owner = OWN_NONE;
  int              m_t     = 0;
  bit              m_lastv = 1'b1;
  logic            e_sdone = 1'b0, e_vdone = 1'b0;
  logic [31:0]     exp_srd = '0, pend_s = '0;
  logic [VLEN-1:0] exp_vrd = '0, pend_v = '0;
  logic [31:0]     ref_mem [256];
  bit              s_seen = 1'b0, v_seen = 1'b0;

  initial begin
    logic [31:0] e_addr, e_wdata;
    logic        e_we, e_act, es, ev, nsd, nvd;
    int          b;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      e_act = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; b = 0;
      if (m_owner == OWN_S && m_t == 1) begin
        e_act = 1'b1; e_addr = {s_addr[31:2], 2'b00}; e_we = s_we; e_wdata = s_wdata;
      end else if (m_owner == OWN_V && m_t >= 1 && m_t <= BEATS) begin
        b = m_t - 1;
        e_act = 1'b1; e_addr = {v_addr[31:2], 2'b00} + 32'(4 * b);
        e_we = v_we; e_wdata = v_wdata[b*DW +: DW];
      end
      check("mem_addr", VLEN'(mem_addr), VLEN'(e_addr));
      check("mem_we", VLEN'(mem_we), VLEN'(e_we));
      check("mem_wdata", VLEN'(mem_wdata), VLEN'(e_wdata));
      check("s_done", VLEN'(s_done), VLEN'(e_sdone));
      check("v_done", VLEN'(v_done), VLEN'(e_vdone));
      check("s_stall", VLEN'(s_stall), VLEN'(s_req & ~e_sdone & ~rst));
      check("v_stall", VLEN'(v_stall), VLEN'(v_req & ~e_vdone & ~rst));
      if (e_sdone) check("s_rdata", VLEN'(s_rdata), VLEN'(exp_srd));
      if (e_vdone) check("v_rdata", v_rdata, exp_vrd);
      s_seen = e_sdone;
      v_seen = e_vdone;
      // The memory access of this cycle happens at the next edge, even if
      // reset is asserted then.
      if (e_act) begin
        if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
        else if (m_owner == OWN_S) pend_s = ref_mem[e_addr[9:2]];
        else pend_v[b*DW +: DW] = ref_mem[e_addr[9:2]];
      end
      nsd = 1'b0; nvd = 1'b0;
      if (rst) begin
        m_owner = OWN_NONE; m_t = 0; m_lastv = 1'b1; exp_srd = '0; exp_vrd = '0;
      end else if (m_owner == OWN_NONE) begin
        es = s_req & ~e_sdone;
        ev = v_req & ~e_vdone;
        if (es && (!ev || m_lastv)) begin
          m_owner = OWN_S; m_t = 1; m_lastv = 1'b0;
        end else if (ev) begin
          m_owner = OWN_V; m_t = 1; m_lastv = 1'b1;
        end
      end else if (m_owner == OWN_S) begin
        if (m_t == 2) begin
          m_owner = OWN_NONE; m_t = 0; nsd = 1'b1;
          if (!s_we) exp_srd = pend_s;
        end else m_t++;
      end else begin
        if (m_t == BEATS + 1) begin
          m_owner = OWN_NONE; m_t = 0; nvd = 1'b1;
          if (!v_we) exp_vrd = pend_v;
        end else m_t++;
      end
      e_sdone = nsd;
      e_vdone = nvd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]     ea, ed;
    logic [VLEN-1:0] ev;
    bit              s_act, v_act;
    rst = 1'b1; s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_s_rdata", VLEN'(s_rdata), '0);
    check("rst_v_rdata", v_rdata, '0);
    check("rst_mem_addr", VLEN'(mem_addr), '0);
    check("rst_mem_we", VLEN'(mem_we), '0);
    check("rst_mem_wdata", VLEN'(mem_wdata), '0);
    check("rst_dones", VLEN'({s_done, v_done}), '0);

    // Scalar load from 0x41 -> word 0x40
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c == 0) begin rst = 0; s_req = 1; s_we = 0; s_addr = 32'h41; end
      if (c == 4) s_req = 0;
      @(negedge clk);
      if (c == 1) check("t1_mem_addr", VLEN'(mem_addr), VLEN'(32'h40));
      if (c <= 3) check("t1_s_stall", VLEN'(s_stall), VLEN'(c < 3));
      if (c == 3) begin
        check("t1_s_done", VLEN'(s_done), VLEN'(1));
        check("t1_s_rdata", VLEN'(s_rdata), VLEN'(32'hDEADBEEF));
      end
    end

    // Vector store to 0x100, lane k = 0x11111111*k
    ev = '0;
    for (int k = 0; k < BEATS; k++) ev[k*DW +: DW] = 32'(32'h11111111 * k);
    for (int c = 0; c <= 11; c++) begin
      tick();
      if (c == 0) begin v_req = 1; v_we = 1; v_addr = 32'h100; v_wdata = ev; end
      if (c == 11) v_req = 0;
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        ea = 32'h100 + 32'(4 * (c - 1));
        ed = 32'(32'h11111111 * (c - 1));
        check("t2_mem_we", VLEN'(mem_we), VLEN'(1));
        check("t2_mem_addr", VLEN'(mem_addr), VLEN'(ea));
        check("t2_mem_wdata", VLEN'(mem_wdata), VLEN'(ed));
      end
      if (c == 9) check("t2_mem_we_off", VLEN'(mem_we), '0);
      if (c <= 10) check("t2_v_done", VLEN'(v_done), VLEN'(c == 10));
    end

    // Vector load of the same region
    for (int c = 0; c <= 11; c++) begin
      tick();
      if (c == 0) begin v_req = 1; v_we = 0; v_addr = 32'h100; v_wdata = '0; end
      if (c == 11) v_req = 0;
      @(negedge clk);
      if (c <= 10) check("t3_v_done", VLEN'(v_done), VLEN'(c == 10));
      if (c == 10) check("t3_v_rdata", v_rdata, ev);
    end

    // Simultaneous requests right after reset, then repeated
    tick(); rst = 1;
    for (int c = 0; c <= 28; c++) begin
      tick();
      if (c == 0) begin rst = 0; s_we = 0; s_addr = 32'h40; v_we = 0; v_addr = 32'h100; end
      s_req = (c <= 3) || (c >= 14 && c <= 17);
      v_req = (c <= 27);
      @(negedge clk);
      check("t4_s_done", VLEN'(s_done), VLEN'(c == 3 || c == 17));
      check("t4_v_done", VLEN'(v_done), VLEN'(c == 13 || c == 27));
      if (c == 1 || c == 15) check("t4_s_addr", VLEN'(mem_addr), VLEN'(32'h40));
      if (c == 4) check("t4_v_first", VLEN'(mem_addr), VLEN'(32'h100));
      if (c == 11) check("t4_v_last", VLEN'(mem_addr), VLEN'(32'h11C));
    end

    // Reset during beat 4 of a vector store, request held
    for (int c = 0; c <= 17; c++) begin
      tick();
      if (c == 0) begin
        v_req = 1; v_we = 1; v_addr = 32'h100;
        for (int k = 0; k < BEATS; k++) v_wdata[k*DW +: DW] = 32'hA0000000 | 32'(k);
      end
      rst = (c == 5);
      if (c == 17) v_req = 0;
      @(negedge clk);
      if (c == 5) begin
        check("t5_beat4_addr", VLEN'(mem_addr), VLEN'(32'h110));
        check("t5_v_stall_rst", VLEN'(v_stall), '0);
      end
      if (c == 6) check("t5_we_abort", VLEN'(mem_we), '0);
      if (c == 7) check("t5_restart", VLEN'({mem_we, mem_addr}), VLEN'({1'b1, 32'h100}));
      if (c <= 16) check("t5_v_done", VLEN'(v_done), VLEN'(c == 16));
    end

    // Address wrap and alignment
    for (int c = 0; c <= 11; c++) begin
      tick();
      if (c == 0) begin
        v_req = 1; v_we = 1; v_addr = 32'hFFFFFFF3;
        for (int k = 0; k < BEATS; k++) v_wdata[k*DW +: DW] = $urandom;
      end
      if (c == 11) v_req = 0;
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        ea = 32'hFFFFFFF0 + 32'(4 * (c - 1));
        check("t6_wrap_addr", VLEN'(mem_addr), VLEN'(ea));
      end
      if (c <= 10) check("t6_v_done", VLEN'(v_done), VLEN'(c == 10));
    end

    // Randomized traffic, occasional reset and mid-operation request drop
    s_act = 0; v_act = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (rst) rst = 0;
      else rst = ($urandom_range(0, 149) == 0);
      if (s_seen) begin s_act = 0; s_req = 0; end
      if (!s_act) begin
        if ($urandom_range(0, 2) == 0) begin
          s_act = 1; s_req = 1; s_we = 1'($urandom_range(0, 1));
          s_addr = $urandom; s_wdata = $urandom;
        end
      end else if (s_req && m_owner == OWN_S && $urandom_range(0, 15) == 0) s_req = 0;
      if (v_seen) begin v_act = 0; v_req = 0; end
      if (!v_act) begin
        if ($urandom_range(0, 3) == 0) begin
          v_act = 1; v_req = 1; v_we = 1'($urandom_range(0, 1)); v_addr = $urandom;
          for (int k = 0; k < BEATS; k++) v_wdata[k*DW +: DW] = $urandom;
        end
      end else if (v_req && m_owner == OWN_V && $urandom_range(0, 15) == 0) v_req = 0;
      if (rst) begin
        if (s_act && !s_req) s_act = 0;
        if (v_act && !v_req) v_act = 0;
      end
    end
    tick();
    rst = 0; s_req = 0; v_req = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single 32-bit data-memory port between the scalar and vector MEM stages of the dual-pipeline core.
- Scalar requests are one word. Vector requests are VLEN-bit and are sequenced as BEATS consecutive word accesses.
- Round-robin arbitration between the two requesters.
- Drives per-pipeline stall outputs, which the pipeline ORs with its load-use stalls to freeze the requesting pipeline until its access completes.

Parameters:
- DATA_W, 32, memory word width in bits.
- VLEN, 256, vector register width in bits.
- BEATS, VLEN/DATA_W = 8, derived; word accesses per vector request.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_req  in  1  scalar access request; held until s_done.
- s_we  in  1  scalar write enable (1 = store, 0 = load).
- s_addr  in  32  scalar byte address; bits [1:0] ignored.
- s_wdata  in  DATA_W  scalar store data.
- s_rdata  out  DATA_W  scalar load result; valid when s_done = 1.
- s_done  out  1  one-cycle completion pulse.
- s_stall  out  1  freeze the scalar pipeline.
- v_req  in  1  vector access request; held until v_done.
- v_we  in  1  vector write enable.
- v_addr  in  32  vector base byte address; bits [1:0] ignored.
- v_wdata  in  VLEN  vector store data; lane k = bits [k*DATA_W +: DATA_W].
- v_rdata  out  VLEN  vector load result; valid when v_done = 1.
- v_done  out  1  one-cycle completion pulse.
- v_stall  out  1  freeze the vector pipeline.
- mem_addr  out  32  memory word-aligned byte address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after the address is presented.

Behaviour:
- Reset values (rst high at a clock edge):
  - state = IDLE, beat = 0, last_grant = VEC.
  - s_done = v_done = 0; s_rdata = 0; v_rdata = 0.
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
- States: IDLE, S_ISSUE, S_RESP, V_ISSUE, V_RESP.
- IDLE:
  - A requester is eligible if its req = 1 and its done = 0 this cycle. This prevents re-granting a request that is being retired.
  - Only one eligible: grant it.
  - Both eligible: grant the one that is not last_grant. last_grant is updated on every grant.
  - Grant scalar -> S_ISSUE. Grant vector -> V_ISSUE with beat = 0.
- S_ISSUE (1 cycle):
  - mem_addr = {s_addr[31:2], 2'b00}; mem_we = s_we; mem_wdata = s_wdata.
  - Next state S_RESP.
- S_RESP (1 cycle):
  - If the access is a load, capture s_rdata <= mem_rdata.
  - Set s_done for the next cycle; next state IDLE.
- V_ISSUE (BEATS cycles):
  - mem_addr = {v_addr[31:2], 2'b00} + 4*beat, modulo 2^32 (wraps).
  - mem_we = v_we; mem_wdata = lane[beat].
  - For beat > 0 and a load, capture lane[beat-1] of v_rdata from mem_rdata.
  - beat increments each cycle. After beat = BEATS-1 -> V_RESP.
- V_RESP (1 cycle):
  - Capture lane[BEATS-1] if the access is a load.
  - Set v_done for the next cycle; next state IDLE.
- Outside issue states: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- s_done and v_done are single-cycle pulses and never coincide.
- Latency, measured from the IDLE grant cycle 0:
  - Scalar: done in cycle 3.
  - Vector: done in cycle BEATS+2 = 10.
  - Stores and loads have identical timing.
- Stall outputs (combinational):
  - s_stall = s_req & ~s_done & ~rst.
  - v_stall = v_req & ~v_done & ~rst.
- Request dropped mid-operation: ignored. The operation completes, any writes commit, and done still pulses.
- Request inputs must stay stable while granted. They are not registered; the arbiter samples them every issue cycle.
- Reset mid-operation:
  - Abort at the next edge; mem_we = 0 from the following cycle.
  - No done pulse. Partially written vector beats remain in memory.
  - After release, held requests are re-arbitrated from scratch and the scalar side wins a tie.
- Back-to-back requests: the IDLE cycle that carries a done pulse may grant the other requester, giving zero idle overhead when both are pending.

Test Plan:
1. Scalar load: preload mem[0x40] = 0xDEADBEEF; s_req = 1, s_we = 0, s_addr = 0x41 at cycle 0 -> mem_addr = 0x40 in cycle 1, s_done = 1 and s_rdata = 0xDEADBEEF in cycle 3, s_stall = 1 in cycles 0–2 and 0 in cycle 3.
2. Vector store: v_req, v_we = 1, v_addr = 0x100, lane k = 0x11111111*k -> mem_we = 1 in cycles 1–8 at 0x100, 0x104, …, 0x11C with data lane k; v_done in cycle 10; mem_we = 0 in cycle 9.
3. Vector load of the same region -> v_done in cycle 10; v_rdata lane k = 0x11111111*k for all 8 lanes.
4. Simultaneous s_req and v_req immediately after reset -> scalar granted, s_done in cycle 3. Vector granted in cycle 3, beats in cycles 4–11, v_done in cycle 13. Repeating both requests -> scalar first again (alternation follows last_grant = VEC).
5. Reset asserted during beat 4 of a vector store -> mem_we = 0 from the next cycle, no v_done, v_stall = 0 while rst = 1. After release with v_req held, the transfer restarts at beat 0, address 0x100.
6. Wrap and alignment: v_addr = 0xFFFFFFF3 -> addresses 0xFFFFFFF0, …F4, …F8, …FC, 0x0, 0x4, 0x8, 0xC.
